// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: consumes a length-prefixed byte stream,
// packs bytes little-endian into words and writes them from address 0 while holding the core.
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [WIDTH-1:0]  wr_din0,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BPW  = WIDTH / 8;
    localparam int BCW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IDXW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t              state_r;
    logic [2:0]          hdr_cnt_r;
    logic [BCW-1:0]      byte_cnt_r;
    logic [IDXW-1:0]     idx_r;
    logic [31:0]         count_r;
    logic [WIDTH-1:0]    word_r;
    logic                rx_ready_r;
    logic                we0_r;
    logic [ADDR_W-1:0]   wr_addr0_r;
    logic [WIDTH-1:0]    wr_din0_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                rx_fire_s;
    logic [31:0]         hdr_full_s;
    logic [WIDTH-1:0]    word_full_s;
    logic [IDXW-1:0]     idx_next_s;

    // Bytes shift in from the top, so after a full word byte k sits at bits [8k+7:8k].
    assign rx_fire_s   = rx_valid && rx_ready_r;
    assign hdr_full_s  = {rx_data, count_r[31:8]};
    assign word_full_s = (word_r >> 8) | (WIDTH'(rx_data) << (WIDTH - 8));
    assign idx_next_s  = idx_r + IDXW'(1);

    assign rx_ready = rx_ready_r;
    assign we0      = we0_r;
    assign wr_addr0 = wr_addr0_r;
    assign wr_din0  = wr_din0_r;
    assign busy     = busy_r;
    assign cpu_hold = busy_r;
    assign done     = done_r;
    assign err      = err_r;

    // Loader FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            hdr_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            idx_r      <= '0;
            count_r    <= 32'd0;
            word_r     <= '0;
            rx_ready_r <= 1'b0;
            we0_r      <= 1'b0;
            wr_addr0_r <= '0;
            wr_din0_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r    <= ST_LEN;
                        hdr_cnt_r  <= 3'd0;
                        byte_cnt_r <= '0;
                        idx_r      <= '0;
                        count_r    <= 32'd0;
                        rx_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (rx_fire_s) begin
                        count_r <= hdr_full_s;
                        if (hdr_cnt_r != 3'd4) begin
                            hdr_cnt_r <= hdr_cnt_r + 3'd1;
                        end
                        if (hdr_cnt_r == 3'd3) begin
                            if (hdr_full_s == 32'd0) begin
                                state_r    <= ST_DONE;
                                rx_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                            end else if (hdr_full_s > 32'(DEPTH)) begin
                                state_r    <= ST_ERR;
                                rx_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                                err_r      <= 1'b1;
                            end else begin
                                state_r    <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire_s) begin
                        word_r <= word_full_s;
                        if (byte_cnt_r == BCW'(BPW - 1)) begin
                            byte_cnt_r <= '0;
                            state_r    <= ST_WRITE;
                            rx_ready_r <= 1'b0;
                            we0_r      <= 1'b1;
                            wr_addr0_r <= ADDR_W'(idx_r) << 2'd2;
                            wr_din0_r  <= word_full_s;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    we0_r <= 1'b0;
                    idx_r <= idx_next_s;
                    if (32'(idx_next_s) == count_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_DATA;
                        rx_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b0;
                    we0_r      <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    err_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-parsing reference model.
module tb_imem_loader;

    localparam int DEPTH  = 128;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [WIDTH-1:0]  wr_din0;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stream_q[$];
    logic [40:0] exp_q[$];
    logic [40:0] got_q[$];
    bit          exp_err;
    int          viol;
    int          wr_pres;

    // Write monitor; also notes bytes offered during a write and any accept during it.
    always @(negedge clk) begin
        if (we0) begin
            got_q.push_back({wr_addr0, wr_din0});
            if (rx_valid) wr_pres++;
            if (rx_ready) viol++;
        end
    end

    // Reference: parse the stream as the loader should, producing the expected write list.
    task automatic model();
        logic [31:0] cnt;
        logic [31:0] w;
        cnt = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        exp_q.delete();
        exp_err = (cnt > 32'(DEPTH));
        if (!exp_err) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = {stream_q[4+4*i+3], stream_q[4+4*i+2], stream_q[4+4*i+1], stream_q[4+4*i]};
                exp_q.push_back({9'(i * 4), w});
            end
        end
    endtask

    task automatic build_stream(input int cnt, input int data_words);
        logic [31:0] c;
        c = 32'(cnt);
        stream_q.delete();
        for (int i = 0; i < 4; i++) stream_q.push_back(c[8*i +: 8]);
        for (int i = 0; i < 4 * data_words; i++) stream_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Pulse start, feed stream bytes (optionally with gaps), then wait for the session to end.
    task automatic run_stream(input bit gaps, input int mid_start_at, input int stop_at);
        bit accepted;
        got_q.delete();
        viol = 0;
        wr_pres = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (i == stop_at) return;
            if (gaps && $urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            rx_valid = 1'b1;
            rx_data  = stream_q[i];
            if (i == mid_start_at) start = 1'b1;
            accepted = 1'b0;
            for (int c = 0; c < 40 && !accepted; c++) begin
                @(negedge clk);
                if (rx_ready) accepted = 1'b1;
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (!accepted) begin
                n_tests++;
                n_fail++;
                $display("FAIL byte_accept_timeout: byte %0d not accepted, required acceptance within 40 cycles", i);
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL session_end_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({rx_ready, we0, busy, cpu_hold, done, err} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/we/busy/hold/done/err=%b required 000000",
                     {rx_ready, we0, busy, cpu_hold, done, err});
        end
        #1 reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input bit gaps);
        stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00};
        run_stream(gaps, -1, -1);
        n_tests++;
        if (got_q.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d writes required 2", got_q.size());
        end else begin
            n_tests += 2;
            if (got_q[0] !== {9'h000, 32'h00500013}) begin
                n_fail++;
                $display("FAIL basic_write0: got %h required %h", got_q[0], {9'h000, 32'h00500013});
            end
            if (got_q[1] !== {9'h004, 32'h00100093}) begin
                n_fail++;
                $display("FAIL basic_write1: got %h required %h", got_q[1], {9'h004, 32'h00100093});
            end
        end
        n_tests++;
        if ({done, cpu_hold, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_status: done/hold/err=%b required 100", {done, cpu_hold, err});
        end
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL ready_during_write: %0d accepts during WRITE required 0", viol);
        end
        if (!gaps) begin
            n_tests++;
            if (wr_pres < 1) begin
                n_fail++;
                $display("FAIL byte_during_write: %0d bytes offered during WRITE required >=1", wr_pres);
            end
        end
    endtask

    task automatic test_bad_len();
        stream_q = '{8'h81, 8'h00, 8'h00, 8'h00};
        run_stream(1'b0, -1, -1);
        repeat (2) @(negedge clk);
        n_tests++;
        if ({err, done, rx_ready, cpu_hold} !== 4'b1000 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bad_len: err/done/rdy/hold=%b writes=%0d required 1000 writes=0",
                     {err, done, rx_ready, cpu_hold}, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        build_stream(2, 2);
        run_stream(1'b0, -1, 6);
        rx_valid = 1'b0;
        n_tests++;
        if (got_q.size() !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: writes=%0d busy=%b required 0 and 1", got_q.size(), busy);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, rx_ready, we0} !== 3'b000 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: busy/rdy/we=%b writes=%0d required 000 writes=0",
                     {busy, rx_ready, we0}, got_q.size());
        end
        @(posedge clk); #1 reset = 1'b1;
        build_stream(2, 2);
        model();
        run_stream(1'b1, -1, -1);
        n_tests++;
        if (got_q != exp_q) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got %0d writes first %h required %0d first %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 41'h0, exp_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_full();
        build_stream(DEPTH, DEPTH);
        model();
        run_stream(1'b0, 100, -1);
        n_tests++;
        if (got_q != exp_q) begin
            n_fail++;
            $display("FAIL full_image: got %0d writes required %0d (or data differs)", got_q.size(), exp_q.size());
        end
        n_tests++;
        if (got_q.size() == 0 || got_q[got_q.size()-1][40:32] !== 9'h1FC) begin
            n_fail++;
            $display("FAIL full_last_addr: got %h required 1fc",
                     got_q.size() > 0 ? got_q[got_q.size()-1][40:32] : 9'h0);
        end
        n_tests++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_status: done/err=%b required 10", {done, err});
        end
    endtask

    task automatic test_random();
        int cnt;
        for (int t = 0; t < 6; t++) begin
            cnt = (t == 0) ? 0 : (t == 1) ? 129 + int'($urandom_range(0, 50)) : int'($urandom_range(1, 6));
            build_stream(cnt, (cnt > DEPTH) ? 0 : cnt);
            model();
            run_stream(1'($urandom_range(0, 1)), -1, -1);
            n_tests++;
            if (got_q != exp_q || err !== exp_err || done !== !exp_err) begin
                n_fail++;
                $display("FAIL random_session: count=%0d writes=%0d err=%b done=%b required writes=%0d err=%b done=%b",
                         cnt, got_q.size(), err, done, exp_q.size(), exp_err, !exp_err);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        reset = 1'b1;
        test_reset();
        test_basic(1'b0);
        test_bad_len();
        test_basic(1'b1);
        test_reset_mid();
        test_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
